// File: rtl/ad6676_capture_sequencer_if.sv
// Bundle of control, stream and status signals between the AD6676 capture
// sequencer and its register map / JESD receive path / DMA.
interface ad6676_capture_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
);
    logic                  cfg_start;
    logic                  cfg_abort;
    logic [LEN_WIDTH-1:0]  cfg_length;
    logic                  trig;
    logic [3:0]            in_sof;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  adc_dovf;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_first;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic                  ovf;
    logic [LEN_WIDTH-1:0]  beat_count;

    modport master (
        output cfg_start, cfg_abort, cfg_length, trig, in_sof, in_valid, in_data, adc_dovf,
        input  out_valid, out_data, out_first, out_last, busy, done, aborted, ovf, beat_count
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_length, trig, in_sof, in_valid, in_data, adc_dovf,
        output out_valid, out_data, out_first, out_last, busy, done, aborted, ovf, beat_count
    );
endinterface

// File: rtl/ad6676_capture_sequencer.sv
// Fixed-length ADC capture sequencer: arm, optional trigger, SOF alignment,
// then forward exactly LENGTH beats to the DMA with done/abort/overflow status.
module ad6676_capture_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter bit TRIGGER_EN = 1'b1
) (
    input  logic                        adc_clk,
    input  logic                        adc_rst,
    ad6676_capture_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic                  trig_d_q;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_first_q, out_first_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  trig_rise_s;
    logic [LEN_WIDTH-1:0]  last_idx_s;
    logic [LEN_WIDTH-1:0]  count_inc_s;

    assign trig_rise_s = bus.trig & ~trig_d_q;
    // Length 0 wraps to all-ones here, so the capture runs the full 2^LEN_WIDTH beats.
    assign last_idx_s  = len_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    assign count_inc_s = count_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    // Next-state, counter and output-register logic; abort overrides every other event.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        if (bus.cfg_abort) begin
            state_d   = ST_IDLE;
            aborted_d = (state_q != ST_IDLE);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_start) begin
                        state_d = ST_ARMED;
                        len_d   = bus.cfg_length;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (!TRIGGER_EN || trig_rise_s) begin
                        state_d = ST_WAIT_SOF;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_WAIT_SOF: begin
                    if (bus.in_valid && bus.in_sof[0]) begin
                        out_valid_d = 1'b1;
                        out_first_d = 1'b1;
                        out_data_d  = bus.in_data;
                        count_d     = count_inc_s;
                        if (len_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                            out_last_d = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            state_d    = ST_CAPTURE;
                        end
                    end else begin
                        state_d = ST_WAIT_SOF;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.adc_dovf) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (bus.in_valid) begin
                        out_valid_d = 1'b1;
                        out_data_d  = bus.in_data;
                        count_d     = count_inc_s;
                        if (count_q == last_idx_s) begin
                            out_last_d = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            state_d    = ST_CAPTURE;
                        end
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            trig_d_q    <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            trig_d_q    <= bus.trig;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_first  = out_first_q;
    assign bus.out_last   = out_last_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.ovf        = ovf_q;
    assign bus.beat_count = count_q;
endmodule

// File: tb/tb_ad6676_capture_sequencer.sv
// Directed bench for ad6676_capture_sequencer: one instance without trigger,
// one with trigger, both fed the same stimulus.
module tb_ad6676_capture_sequencer;
    logic adc_clk;
    logic adc_rst;
    int   n_checks;
    int   n_errors;
    int   n_beats;

    ad6676_capture_sequencer_if #(.DATA_WIDTH(64), .LEN_WIDTH(16)) if0 ();
    ad6676_capture_sequencer_if #(.DATA_WIDTH(64), .LEN_WIDTH(16)) if1 ();

    assign if1.cfg_start  = if0.cfg_start;
    assign if1.cfg_abort  = if0.cfg_abort;
    assign if1.cfg_length = if0.cfg_length;
    assign if1.trig       = if0.trig;
    assign if1.in_sof     = if0.in_sof;
    assign if1.in_valid   = if0.in_valid;
    assign if1.in_data    = if0.in_data;
    assign if1.adc_dovf   = if0.adc_dovf;

    ad6676_capture_sequencer #(.DATA_WIDTH(64), .LEN_WIDTH(16), .TRIGGER_EN(1'b0)) u_dut_notrig (
        .adc_clk (adc_clk),
        .adc_rst (adc_rst),
        .bus     (if0)
    );

    ad6676_capture_sequencer #(.DATA_WIDTH(64), .LEN_WIDTH(16), .TRIGGER_EN(1'b1)) u_dut_trig (
        .adc_clk (adc_clk),
        .adc_rst (adc_rst),
        .bus     (if1)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] s, input logic [63:0] d);
        if0.in_valid = v;
        if0.in_sof   = s;
        if0.in_data  = d;
    endtask

    task automatic clean;
        if0.cfg_abort = 1'b1;
        drv(1'b0, 4'd0, 64'd0);
        cyc();
        if0.cfg_abort = 1'b0;
        cyc();
    endtask

    // Start pulse then the ARMED cycle; the no-trigger instance is in WAIT_SOF afterwards.
    task automatic start_cap(input logic [15:0] len);
        drv(1'b0, 4'd0, 64'd0);
        if0.cfg_start  = 1'b1;
        if0.cfg_length = len;
        cyc();
        check_val("start_busy", {63'd0, if0.busy}, 64'd1);
        if0.cfg_start = 1'b0;
        cyc();
    endtask

    function automatic logic [63:0] dat(input int t, input int i);
        return (64'(t) << 32) | 64'(i);
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        adc_rst = 1'b1;
        if0.cfg_start = 1'b0; if0.cfg_abort = 1'b0; if0.cfg_length = 16'd0;
        if0.trig = 1'b0; if0.adc_dovf = 1'b0;
        drv(1'b0, 4'd0, 64'd0);
        cyc(); cyc();
        adc_rst = 1'b0;
        cyc();
        check_val("rst_busy", {63'd0, if0.busy}, 64'd0);
        check_val("rst_valid", {63'd0, if0.out_valid}, 64'd0);
        check_val("rst_data", if0.out_data, 64'd0);
        check_val("rst_ovf", {63'd0, if0.ovf}, 64'd0);
        check_val("rst_count", {48'd0, if0.beat_count}, 64'd0);
        check_val("rst_busy_trig", {63'd0, if1.busy}, 64'd0);

        // Basic capture: length 8, sof on beats 3,7,11,15 -> beats 3..10 forwarded.
        start_cap(16'd8);
        n_beats = 0;
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, (i % 4 == 3) ? 4'b0001 : 4'b0000, dat(1, i));
            cyc();
            check_val("b_valid", {63'd0, if0.out_valid}, (i >= 3 && i <= 10) ? 64'd1 : 64'd0);
            check_val("b_first", {63'd0, if0.out_first}, (i == 3) ? 64'd1 : 64'd0);
            check_val("b_last", {63'd0, if0.out_last}, (i == 10) ? 64'd1 : 64'd0);
            check_val("b_done", {63'd0, if0.done}, (i == 11) ? 64'd1 : 64'd0);
            if (if0.out_valid) begin
                check_val("b_data", if0.out_data, dat(1, i));
                n_beats = n_beats + 1;
            end
        end
        check_val("b_nbeats", 64'(n_beats), 64'd8);
        check_val("b_count", {48'd0, if0.beat_count}, 64'd8);
        check_val("b_busy", {63'd0, if0.busy}, 64'd0);

        // Trigger wait: trigger instance has sat in ARMED; abort it first.
        clean();
        check_val("t_pre_abort_idle", {63'd0, if1.busy}, 64'd0);
        start_cap(16'd4);
        n_beats = 0;
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, (i % 4 == 3) ? 4'b0001 : 4'b0000, dat(2, i));
            cyc();
            if (if1.out_valid) n_beats = n_beats + 1;
        end
        check_val("t_no_early_beats", 64'(n_beats), 64'd0);
        check_val("t_still_busy", {63'd0, if1.busy}, 64'd1);
        if0.trig = 1'b1;
        for (int i = 20; i < 32; i++) begin
            drv(1'b1, (i % 4 == 3) ? 4'b0001 : 4'b0000, dat(2, i));
            cyc();
            check_val("t_valid", {63'd0, if1.out_valid}, (i >= 23 && i <= 26) ? 64'd1 : 64'd0);
            check_val("t_first", {63'd0, if1.out_first}, (i == 23) ? 64'd1 : 64'd0);
            check_val("t_done", {63'd0, if1.done}, (i == 27) ? 64'd1 : 64'd0);
            if (if1.out_valid) check_val("t_data", if1.out_data, dat(2, i));
        end
        check_val("t_count", {48'd0, if1.beat_count}, 64'd4);
        if0.trig = 1'b0;

        // Gappy input: valid on even cycles, sof only on the first beat.
        clean();
        start_cap(16'd5);
        for (int i = 0; i < 14; i++) begin
            drv((i % 2 == 0), (i == 0) ? 4'b0001 : 4'b0000, dat(3, i));
            cyc();
            check_val("g_valid", {63'd0, if0.out_valid}, (i % 2 == 0 && i <= 8) ? 64'd1 : 64'd0);
            check_val("g_last", {63'd0, if0.out_last}, (i == 8) ? 64'd1 : 64'd0);
            check_val("g_done", {63'd0, if0.done}, (i == 9) ? 64'd1 : 64'd0);
            if (if0.out_valid) check_val("g_data", if0.out_data, dat(3, i));
        end
        check_val("g_count", {48'd0, if0.beat_count}, 64'd5);

        // Abort at beat 3 of 10, together with a start pulse.
        clean();
        start_cap(16'd10);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, (i == 0) ? 4'b0001 : 4'b0000, dat(4, i));
            cyc();
            check_val("a_valid", {63'd0, if0.out_valid}, 64'd1);
        end
        drv(1'b1, 4'b0001, dat(4, 3));
        if0.cfg_abort  = 1'b1;
        if0.cfg_start  = 1'b1;
        if0.cfg_length = 16'd7;
        cyc();
        check_val("a_aborted", {63'd0, if0.aborted}, 64'd1);
        check_val("a_valid_abort", {63'd0, if0.out_valid}, 64'd0);
        check_val("a_busy", {63'd0, if0.busy}, 64'd0);
        check_val("a_done", {63'd0, if0.done}, 64'd0);
        check_val("a_count", {48'd0, if0.beat_count}, 64'd3);
        if0.cfg_abort = 1'b0;
        if0.cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("a_aborted_pulse", {63'd0, if0.aborted}, 64'd0);
            check_val("a_done_after", {63'd0, if0.done}, 64'd0);
            check_val("a_busy_after", {63'd0, if0.busy}, 64'd0);
        end

        // Overflow during CAPTURE, sticky through DONE, cleared by the next start.
        clean();
        start_cap(16'd4);
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, (i == 0) ? 4'b0001 : 4'b0000, dat(5, i));
            if0.adc_dovf = (i == 1);
            cyc();
            check_val("o_ovf", {63'd0, if0.ovf}, (i >= 1) ? 64'd1 : 64'd0);
            check_val("o_done", {63'd0, if0.done}, (i == 4) ? 64'd1 : 64'd0);
        end
        if0.adc_dovf = 1'b0;
        drv(1'b0, 4'd0, 64'd0);
        if0.cfg_start  = 1'b1;
        if0.cfg_length = 16'd1;
        cyc();
        check_val("o_ovf_cleared", {63'd0, if0.ovf}, 64'd0);
        check_val("o_count_cleared", {48'd0, if0.beat_count}, 64'd0);
        if0.cfg_start = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 4'b0000, dat(6, i));
            cyc();
            check_val("l1_drop", {63'd0, if0.out_valid}, 64'd0);
        end
        drv(1'b1, 4'b0001, dat(6, 9));
        cyc();
        check_val("l1_valid", {63'd0, if0.out_valid}, 64'd1);
        check_val("l1_first", {63'd0, if0.out_first}, 64'd1);
        check_val("l1_last", {63'd0, if0.out_last}, 64'd1);
        check_val("l1_data", if0.out_data, dat(6, 9));
        drv(1'b1, 4'b0001, dat(6, 10));
        cyc();
        check_val("l1_done", {63'd0, if0.done}, 64'd1);
        check_val("l1_no_more", {63'd0, if0.out_valid}, 64'd0);
        check_val("l1_count", {48'd0, if0.beat_count}, 64'd1);

        // Reset at beat 2 of 6, then a complete 6-beat capture.
        clean();
        start_cap(16'd6);
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, (i == 0) ? 4'b0001 : 4'b0000, dat(7, i));
            cyc();
        end
        drv(1'b1, 4'b0000, dat(7, 2));
        adc_rst = 1'b1;
        cyc();
        adc_rst = 1'b0;
        check_val("r_valid", {63'd0, if0.out_valid}, 64'd0);
        check_val("r_data", if0.out_data, 64'd0);
        check_val("r_busy", {63'd0, if0.busy}, 64'd0);
        check_val("r_count", {48'd0, if0.beat_count}, 64'd0);
        check_val("r_done", {63'd0, if0.done}, 64'd0);
        check_val("r_aborted", {63'd0, if0.aborted}, 64'd0);
        start_cap(16'd6);
        n_beats = 0;
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, (i == 0) ? 4'b0001 : 4'b0000, dat(8, i));
            cyc();
            check_val("r2_last", {63'd0, if0.out_last}, (i == 5) ? 64'd1 : 64'd0);
            check_val("r2_done", {63'd0, if0.done}, (i == 6) ? 64'd1 : 64'd0);
            if (if0.out_valid) n_beats = n_beats + 1;
        end
        check_val("r2_nbeats", 64'(n_beats), 64'd6);
        check_val("r2_count", {48'd0, if0.beat_count}, 64'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
